// File: rtl/seg7_pkg.sv
// Shared 7-segment glyphs ({g,f,e,d,c,b,a}, active-high) and the anode one-hot helper.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes above 9 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner: captures packed BCD digits into a shadow register
// and cycles them onto a shared segment bus with leading-zero blanking.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic                       tc;
  logic                       hi_zero;
  logic [NUM_DIGITS-1:0]      lz_mask;
  logic [6:0]                 seg_dec;
  logic [NUM_DIGITS-1:0]      an_dec;

  assign tc     = (cnt == CNT_LAST);
  assign an_dec = NUM_DIGITS'(onehot(3'(idx)));

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    hi_zero = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero    = hi_zero & (shadow[i] == 4'd0);
      lz_mask[i] = hi_zero;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (shadow[idx]),
    .blank (blank_lz & lz_mask[idx]),
    .seg   (seg_dec)
  );

  // Scan control, shadow capture and polarity-corrected output stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      seg       <= SEG_INV;
      dp        <= DP_INV;
      an        <= AN_INV;
      frame     <= 1'b0;
    end else begin
      cnt   <= tc ? '0 : cnt + 1'b1;
      frame <= tc && (idx == IDX_LAST);
      if (tc) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        shadow    <= bcd_in;
        shadow_dp <= dp_en;
      end
      seg <= seg_dec ^ SEG_INV;
      dp  <= shadow_dp[idx] ^ DP_INV;
      an  <= an_dec ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: table vectors, corner sequences, random run.
module tb_bcd_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_in   (bcd_in),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .frame    (frame)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset release plus the last captured value
  int          e = 0;
  int          last_d = -1;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_frame;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpe;
    logic            blz;
    logic [3:0][6:0] segx;
    logic [3:0]      dpx;
  } vec_t;

  vec_t tv[7];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    int   d;
    logic blank;
    @(posedge clk);
    if (!reset) begin
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_frame = 1'b0;
      e = 0; last_d = -1; m_shadow = '0; m_dp = '0;
    end else begin
      d = (e / R) % N;
      blank = blank_lz && (d > 0) && ((m_shadow >> (4 * d)) == 16'd0);
      exp_seg   = ~(blank ? 7'h00 : glyph(m_shadow[4*d +: 4]));
      exp_dp    = ~m_dp[d];
      exp_an    = ~(4'b0001 << d);
      exp_frame = (((e + 1) % (R * N)) == 0);
      last_d = d;
      e++;
      if (load) begin
        m_shadow = bcd_in;
        m_dp     = dp_en;
      end
    end
    #1;
    check("cycle", {seg, dp, an, frame}, {exp_seg, exp_dp, exp_an, exp_frame});
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] dpv, input logic blz);
    bcd_in = v; dp_en = dpv; blank_lz = blz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int frames;
    int multi;
    int k;
    logic [15:0] nv;

    tv[0] = '{16'h1234, 4'h0, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF};
    tv[1] = '{16'h0050, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'hF};
    tv[2] = '{16'h0050, 4'h0, 1'b0, {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'hF};
    tv[3] = '{16'h00A7, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'b0111111, 7'b1111000}, 4'b1101};
    tv[4] = '{16'h9999, 4'b1001, 1'b1, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}, 4'b0110};
    tv[5] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1011};
    tv[6] = '{16'h8060, 4'h0, 1'b1, {7'b0000000, 7'b1000000, 7'b0000010, 7'b1000000}, 4'hF};

    reset = 1'b0; bcd_in = 16'h5555; load = 1'b1; blank_lz = 1'b0; dp_en = 4'hF;
    for (int i = 0; i < 3; i++) step();
    check("rst_state", {2'b0, an, seg}, {2'b0, 4'hF, 7'h7F});
    load = 1'b0;
    reset = 1'b1;
    step();
    check("first_edge", {2'b0, an, seg}, {2'b0, 4'b1110, 7'b1000000});

    frames = 0; multi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame) frames++;
      if ($countones(~an) != 1) multi++;
    end
    check("frame_cnt", 13'(frames), 13'd2);
    check("onehot", 13'(multi), 13'd0);

    foreach (tv[i]) begin
      load_value(tv[i].bcd, tv[i].dpe, tv[i].blz);
      for (int c = 0; c < R * N; c++) begin
        step();
        check("tbl_seg", {6'b0, seg}, {6'b0, tv[i].segx[last_d]});
        check("tbl_dp", {12'b0, dp}, {12'b0, tv[i].dpx[last_d]});
      end
    end

    // Reset in the middle of digit 2 after loading 9999
    blank_lz = 1'b0;
    load_value(16'h9999, 4'h0, 1'b0);
    k = 0;
    while (k < 64 && !(last_d == 2 && (e % R) == 2)) begin step(); k++; end
    check("reach_d2", {11'b0, (k < 64), 1'b0}, {11'b0, 1'b1, 1'b0});
    reset = 1'b0;
    step();
    check("mid_rst_an", {9'b0, an}, {9'b0, 4'hF});
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      step();
      check("post_rst", {2'b0, an, seg}, {2'b0, ~(4'b0001 << (i / R)), 7'b1000000});
    end

    // Load coinciding with the prescaler terminal count
    k = 0;
    while (k < 16 && (e % R) != R - 1) begin step(); k++; end
    nv = 16'h5678;
    load_value(nv, 4'h0, 1'b0);
    step();
    check("load_tc", {6'b0, seg}, {6'b0, ~glyph(nv[4*last_d +: 4])});

    // Random traffic against the model
    multi = 0;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) != 0);
      load     = ($urandom_range(0, 7) == 0);
      bcd_in   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_en    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step();
      if (reset && $countones(~an) != 1) multi++;
    end
    check("rand_onehot", 13'(multi), 13'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
